// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter: bus widths,
// the transfer-phase state encoding and the default access timeout.
package apb_arb_pkg;

    localparam int APB_DW                 = 32;
    localparam int APB_AW                 = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    // Phases of one APB transfer as seen by the arbiter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    // Width of an index into n requesters; never zero, so single-requester
    // builds still get a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled so the
// arbiter and its environment connect through a single port.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import apb_arb_pkg::*;

    // Requester side: packed per-requester fields, requester k at slice k.
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        i_req_write;
    logic [NUM_REQ*APB_AW-1:0] i_req_addr;
    logic [NUM_REQ*APB_DW-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]        o_req_ack;
    logic [APB_DW-1:0]         o_rsp_rdata;
    logic                      o_rsp_err;
    logic [NUM_REQ-1:0]        o_grant;

    // APB master side.
    logic                      o_apb_psel;
    logic                      o_apb_penable;
    logic                      o_apb_pwrite;
    logic [APB_AW-1:0]         o_apb_paddr;
    logic [APB_DW-1:0]         o_apb_pwdata;
    logic                      i_apb_pready;
    logic                      i_apb_pserr;
    logic [APB_DW-1:0]         i_apb_prdata;

    // The arbiter drives requests onto APB.
    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output o_req_ack, o_rsp_rdata, o_rsp_err, o_grant,
        output o_apb_psel, o_apb_penable, o_apb_pwrite, o_apb_paddr, o_apb_pwdata,
        input  i_apb_pready, i_apb_pserr, i_apb_prdata
    );

    // Requesters plus APB slave: the mirror image of the arbiter.
    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  o_req_ack, o_rsp_rdata, o_rsp_err, o_grant,
        input  o_apb_psel, o_apb_penable, o_apb_pwrite, o_apb_paddr, o_apb_pwdata,
        output i_apb_pready, i_apb_pserr, i_apb_prdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: combinational pick over the request vector starting
// at a registered pointer; the pointer moves past the winner when the
// grant is taken, so the winner becomes lowest priority next time.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_take,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               req_any
);

    // Index where the next search begins; 0 after reset so requester 0
    // wins the first contest.
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    // Pick the first requesting index at or after the pointer, wrapping.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // skips an assignment in always_comb would infer a latch.
        grant     = '0;
        grant_idx = '0;
        req_any   = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!req_any && req[cand]) begin
                req_any     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Slot after the current winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + IDX_W'(1);
        end
    end

    // Advance the search pointer only when the grant is actually used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant_take) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NUM_REQ register-access requesters.
// A granted request is registered onto APB, run through SETUP and ACCESS
// (bounded by an access timeout), and answered with a one-cycle ack that
// carries the captured read data and error flag.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              i_apb_clk,
    input  logic              i_apb_rst_n,
    apb_req_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_req_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    apb_state_e          state_q;
    apb_state_e          state_d;

    logic [NUM_REQ-1:0]  grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pwrite_q;
    logic [APB_AW-1:0]   paddr_q;
    logic [APB_DW-1:0]   pwdata_q;
    logic [APB_DW-1:0]   rdata_q;
    logic                err_q;

    logic                take_req;
    logic                capture_rsp;
    logic                timed_out;

    logic [NUM_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_any;

    logic [APB_AW-1:0]   req_addr  [NUM_REQ];
    logic [APB_DW-1:0]   req_wdata [NUM_REQ];

    // Unpack the per-requester fields so the winner can be selected by index.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_addr[k]  = bus.i_req_addr[k*APB_AW +: APB_AW];
        assign req_wdata[k] = bus.i_req_wdata[k*APB_DW +: APB_DW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk        (i_apb_clk),
        .rst_n      (i_apb_rst_n),
        .req        (bus.i_req_valid),
        .grant_take (take_req),
        .grant      (rr_grant),
        .grant_idx  (rr_idx),
        .req_any    (rr_any)
    );

    // Next-phase decision plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_d     = state_q;
        take_req    = 1'b0;
        capture_rsp = 1'b0;
        timed_out   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    take_req = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A slave answer on the last allowed cycle beats the timeout.
                if (bus.i_apb_pready) begin
                    capture_rsp = 1'b1;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase register.
    always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
        if (!i_apb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register the winning request; the copy lets the requester drop valid
    // mid-transfer. APB fields hold their values between transfers.
    always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
        if (!i_apb_rst_n) begin
            grant_q  <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (take_req) begin
            grant_q  <= rr_grant;
            pwrite_q <= bus.i_req_write[rr_idx];
            paddr_q  <= req_addr[rr_idx];
            pwdata_q <= req_wdata[rr_idx];
        end else if (state_q == ST_DONE) begin
            grant_q  <= '0;
        end
    end

    // Count ACCESS cycles; held at zero elsewhere so every ACCESS starts at 0.
    always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
        if (!i_apb_rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Capture the response; err is only ever high during the DONE cycle,
    // while read data keeps its last value.
    always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
        if (!i_apb_rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (capture_rsp) begin
            rdata_q <= bus.i_apb_prdata;
            err_q   <= bus.i_apb_pserr;
        end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else begin
            err_q   <= 1'b0;
        end
    end

    assign bus.o_apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.o_apb_penable = (state_q == ST_ACCESS);
    assign bus.o_apb_pwrite  = pwrite_q;
    assign bus.o_apb_paddr   = paddr_q;
    assign bus.o_apb_pwdata  = pwdata_q;
    assign bus.o_grant       = grant_q;
    assign bus.o_req_ack     = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.o_rsp_rdata   = rdata_q;
    assign bus.o_rsp_err     = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a table of single transfers, hand-written
// contention and reset sequences, then random traffic against a
// transaction-timing reference model.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int NR = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(NR)) bus();

    apb_req_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_apb_clk   (clk),
        .i_apb_rst_n (rst_n),
        .bus         (bus)
    );

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        bit          pserr;
        bit          drop;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int k);
        logic [NR-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic drive_req(input int k, input bit v, input bit wr,
                             input logic [31:0] a, input logic [31:0] d);
        bus.i_req_valid[k]          = v;
        bus.i_req_write[k]          = wr;
        bus.i_req_addr[k*32 +: 32]  = a;
        bus.i_req_wdata[k*32 +: 32] = d;
    endtask

    task automatic clear_inputs();
        bus.i_req_valid  = '0;
        bus.i_req_write  = '0;
        bus.i_req_addr   = '0;
        bus.i_req_wdata  = '0;
        bus.i_apb_pready = 1'b0;
        bus.i_apb_pserr  = 1'b0;
        bus.i_apb_prdata = '0;
    endtask

    // One transfer from an idle arbiter; called at the negedge of an IDLE cycle
    // and returns at the negedge of the IDLE cycle after the ack.
    task automatic do_xfer(input vec_t v);
        logic [NR-1:0] oh;
        bit            done;
        int            j;
        oh   = onehot(v.idx);
        done = 1'b0;
        j    = 0;
        drive_req(v.idx, 1'b1, v.wr, v.addr, v.wdata);
        bus.i_apb_pready = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("setup_psel", bus.o_apb_psel, 1);
                check("setup_penable", bus.o_apb_penable, 0);
                check("setup_grant", bus.o_grant, oh);
                check("setup_paddr", bus.o_apb_paddr, v.addr);
                check("setup_pwrite", bus.o_apb_pwrite, v.wr);
                if (v.wr) check("setup_pwdata", bus.o_apb_pwdata, v.wdata);
            end
            if (n == 2) begin
                check("access_psel", bus.o_apb_psel, 1);
                check("access_penable", bus.o_apb_penable, 1);
            end
            if (bus.o_req_ack != '0) begin
                done = 1'b1;
                check("xfer_ack_vec", bus.o_req_ack, oh);
                check("xfer_latency", n, v.exp_lat);
                check("xfer_rdata", bus.o_rsp_rdata, v.exp_rdata);
                check("xfer_err", bus.o_rsp_err, v.exp_err);
                check("done_psel", bus.o_apb_psel, 0);
                bus.i_apb_pready = 1'b0;
            end else begin
                if (v.drop && n == 1) begin
                    drive_req(v.idx, 1'b0, ~v.wr, ~v.addr, ~v.wdata);
                end
                if (bus.o_apb_penable) begin
                    bus.i_apb_pready = (j == v.waits);
                    bus.i_apb_prdata = (j == v.waits) ? v.prdata : ~v.prdata;
                    bus.i_apb_pserr  = (j == v.waits) ? v.pserr : 1'b1;
                    j++;
                end else begin
                    bus.i_apb_pready = 1'b0;
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL xfer_ack_wait: no ack within 40 cycles, required latency %0d", v.exp_lat);
        end
        @(negedge clk);
        drive_req(v.idx, 1'b0, 1'b0, 32'h0, 32'h0);
        check("idle_grant", bus.o_grant, 0);
        check("idle_psel", bus.o_apb_psel, 0);
        check("idle_err", bus.o_rsp_err, 0);
        check("idle_rdata_hold", bus.o_rsp_rdata, v.exp_rdata);
        check("idle_paddr_hold", bus.o_apb_paddr, v.addr);
    endtask

    // Random traffic: the model predicts each transfer's timing window from
    // its grant cycle and slave wait count, and RR order from the last winner.
    task automatic random_phase(input int cycles);
        bit          busy;
        int          free_at, g_t, ack_t, waits, owner, rr_next, eff;
        logic [31:0] exp_rdata, resp_data, x_addr, x_wdata;
        bit          exp_err, resp_err, x_wr;
        bit          outst[NR];
        int          ack_cycle[NR];
        logic [NR-1:0] oh;
        busy = 0; free_at = 0; rr_next = 0; owner = 0; g_t = -10; ack_t = -10; waits = 0;
        exp_rdata = '0; exp_err = 0; resp_data = '0; resp_err = 0;
        x_addr = '0; x_wdata = '0; x_wr = 0;
        for (int k = 0; k < NR; k++) begin
            outst[k] = 0;
            ack_cycle[k] = -10;
        end
        for (int t = 0; t < cycles; t++) begin
            oh = busy ? onehot(owner) : '0;
            check("rnd_ack", bus.o_req_ack, (busy && t == ack_t) ? oh : '0);
            check("rnd_grant", bus.o_grant, (busy && t > g_t && t <= ack_t) ? oh : '0);
            check("rnd_psel", bus.o_apb_psel, busy && t > g_t && t < ack_t);
            check("rnd_penable", bus.o_apb_penable, busy && t >= g_t + 2 && t < ack_t);
            if (busy && t == g_t + 1) begin
                check("rnd_paddr", bus.o_apb_paddr, x_addr);
                check("rnd_pwrite", bus.o_apb_pwrite, x_wr);
                check("rnd_pwdata", bus.o_apb_pwdata, x_wdata);
            end
            if (busy && t == ack_t) begin
                check("rnd_rdata", bus.o_rsp_rdata, exp_rdata);
                check("rnd_err", bus.o_rsp_err, exp_err);
                outst[owner]     = 0;
                ack_cycle[owner] = t;
                busy             = 0;
                free_at          = t + 1;
                rr_next          = (owner + 1) % NR;
            end else begin
                check("rnd_err_quiet", bus.o_rsp_err, 0);
            end
            // Requesters: new work only from the cycle after their ack.
            for (int k = 0; k < NR; k++) begin
                if (!outst[k]) begin
                    if (t > ack_cycle[k]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            outst[k] = 1;
                            drive_req(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                        end else begin
                            bus.i_req_valid[k] = 1'b0;
                        end
                    end
                end else if (busy && owner == k && t > g_t && $urandom_range(0, 7) == 0) begin
                    drive_req(k, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
            // Grant decision for an idle arbiter.
            if (!busy && t >= free_at && bus.i_req_valid != '0) begin
                for (int i = NR - 1; i >= 0; i--) begin
                    if (bus.i_req_valid[(rr_next + i) % NR]) owner = (rr_next + i) % NR;
                end
                g_t       = t;
                x_wr      = bus.i_req_write[owner];
                x_addr    = bus.i_req_addr[owner*32 +: 32];
                x_wdata   = bus.i_req_wdata[owner*32 +: 32];
                waits     = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(13, 20);
                resp_data = $urandom;
                resp_err  = 1'($urandom_range(0, 1));
                eff       = (waits < TO - 1) ? waits : TO - 1;
                ack_t     = t + 3 + eff;
                exp_err   = (waits <= TO - 1) ? resp_err : 1'b1;
                exp_rdata = (waits <= TO - 1) ? resp_data : 32'h0;
                busy      = 1;
            end
            // Slave: answer on the chosen ACCESS cycle, junk elsewhere.
            if (busy && t >= g_t + 2 && t < ack_t && (t - g_t - 2) == waits) begin
                bus.i_apb_pready = 1'b1;
                bus.i_apb_prdata = resp_data;
                bus.i_apb_pserr  = resp_err;
            end else begin
                bus.i_apb_pready = 1'b0;
                bus.i_apb_prdata = $urandom;
                bus.i_apb_pserr  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_ack;
        vecs[0] = '{0, 1, 32'h0000_0100, 32'hA5A5_5A5A, 0,  32'h0000_0000, 0, 0, 3,  32'h0000_0000, 0};
        vecs[1] = '{1, 0, 32'h0000_0200, 32'h0000_0000, 3,  32'h1234_5678, 0, 0, 6,  32'h1234_5678, 0};
        vecs[2] = '{0, 0, 32'h0000_0300, 32'h0000_0000, 1,  32'hCAFE_F00D, 1, 0, 4,  32'hCAFE_F00D, 1};
        vecs[3] = '{1, 1, 32'h0000_0400, 32'h1111_2222, 20, 32'hFFFF_FFFF, 0, 0, 18, 32'h0000_0000, 1};
        vecs[4] = '{0, 0, 32'h0000_0500, 32'h0000_0000, 15, 32'h0BAD_BEEF, 0, 0, 18, 32'h0BAD_BEEF, 0};
        vecs[5] = '{1, 0, 32'h0000_0600, 32'h0000_0000, 14, 32'h55AA_33CC, 1, 0, 17, 32'h55AA_33CC, 1};
        vecs[6] = '{0, 1, 32'h0000_0700, 32'hDEAD_BEEF, 2,  32'h600D_F00D, 0, 1, 5,  32'h600D_F00D, 0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_psel", bus.o_apb_psel, 0);
        check("rst_penable", bus.o_apb_penable, 0);
        check("rst_pwrite", bus.o_apb_pwrite, 0);
        check("rst_paddr", bus.o_apb_paddr, 0);
        check("rst_pwdata", bus.o_apb_pwdata, 0);
        check("rst_grant", bus.o_grant, 0);
        check("rst_ack", bus.o_req_ack, 0);
        check("rst_rdata", bus.o_rsp_rdata, 0);
        check("rst_err", bus.o_rsp_err, 0);

        // Table of single transfers.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) do_xfer(vecs[i]);

        // Both requesters valid from reset: grants alternate, ack every 4 cycles.
        rst_n = 1'b0;
        drive_req(0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0010);
        drive_req(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0020);
        bus.i_apb_pready = 1'b1;
        bus.i_apb_pserr  = 1'b0;
        bus.i_apb_prdata = 32'h0000_0077;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp_ack = '0;
            if (n % 4 == 3) exp_ack = onehot((n / 4) % 2);
            check("rr_ack", bus.o_req_ack, exp_ack);
            if (n % 4 == 1) begin
                check("rr_grant", bus.o_grant, onehot((n / 4) % 2));
                check("rr_paddr", bus.o_apb_paddr, ((n / 4) % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            end
        end

        // Reset in the middle of ACCESS: async drop, no ack, req0 first after.
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_penable", bus.o_apb_penable, 1);
        check("mid_grant", bus.o_grant, 2'b10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_psel", bus.o_apb_psel, 0);
        check("async_penable", bus.o_apb_penable, 0);
        check("async_grant", bus.o_grant, 0);
        check("async_paddr", bus.o_apb_paddr, 0);
        drive_req(0, 1'b1, 1'b1, 32'h0000_0900, 32'h0000_0099);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_no_ack", bus.o_req_ack, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", bus.o_grant, 2'b01);
        check("post_rst_psel", bus.o_apb_psel, 1);
        check("post_rst_paddr", bus.o_apb_paddr, 32'h0000_0900);

        // Random traffic from a fresh reset.
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        random_phase(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of register-access requesters (init sequencer = index 0, host control plane = index 1).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum ACCESS-phase cycles before forced termination; legal range 2..65535.
REQ-003 The block SHALL have one clock, i_apb_clk; reset is asynchronous and active-low, i_apb_rst_n.
REQ-004 i_apb_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_apb_rst_n  in  1  async active-low reset.
REQ-006 i_req_valid  in  NUM_REQ  per-requester request pending.
REQ-007 i_req_write  in  NUM_REQ  1 = write, 0 = read.
REQ-008 i_req_addr  in  NUM_REQ*32  packed addresses, requester k at bits [32k+31:32k].
REQ-009 i_req_wdata  in  NUM_REQ*32  packed write data, same packing.
REQ-010 o_req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 o_rsp_rdata  out  32  read data, valid only while an o_req_ack bit is high.
REQ-012 o_rsp_err  out  1  slave error or timeout, valid only while an o_req_ack bit is high.
REQ-013 o_grant  out  NUM_REQ  one-hot owner of the current transfer, 0 when idle.
REQ-014 o_apb_psel, o_apb_penable, o_apb_pwrite  out  1 each  APB master controls.
REQ-015 o_apb_paddr, o_apb_pwdata  out  32 each  APB address and write data.
REQ-016 i_apb_pready, i_apb_pserr  in  1 each  APB completion and slave error.
REQ-017 i_apb_prdata  in  32  APB read data.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, DONE; transitions only on i_apb_clk.
REQ-019 IDLE: if any i_req_valid is set, grant one requester round-robin, register its write/addr/wdata onto the APB outputs, and go to SETUP; otherwise stay in IDLE.
REQ-020 Round-robin: search starts at (last_grant+1) mod NUM_REQ; pointer resets to 0, so requester 0 wins the first simultaneous contest.
REQ-021 SETUP: psel=1, penable=0; unconditionally go to ACCESS.
REQ-022 ACCESS: psel=1, penable=1; when i_apb_pready=1, capture prdata and pserr and go to DONE.
REQ-023 Timeout: the ACCESS cycle counter clears on entry to ACCESS; if the counter reaches TIMEOUT_CYCLES-1 with pready=0, go to DONE with err=1 and rdata=32'h0000_0000.
REQ-024 If pready and the timeout occur in the same cycle, pready wins; err=pserr and rdata=prdata.
REQ-025 DONE: psel=0, penable=0; o_req_ack[grant]=1 for exactly one cycle, with o_rsp_rdata/o_rsp_err registered; then go to IDLE.
REQ-026 Latency: valid sampled in IDLE at cycle 0 with zero-wait pready gives ack in cycle 3; back-to-back throughput is one transfer per 4 cycles.
REQ-027 Requester handshake: valid and its fields stay stable until ack; valid is low or carries a new request from the cycle after ack.
REQ-028 If the granted requester drops valid mid-transfer, the transfer completes on the registered copy and ack still pulses.
REQ-029 paddr/pwdata/pwrite hold their last values outside a transfer; o_rsp_rdata holds its last value and o_rsp_err reads 0 outside DONE.
REQ-030 o_grant is one-hot from SETUP through DONE and 0 in IDLE.

Reset
REQ-031 While i_apb_rst_n=0: state IDLE, all outputs 0, RR pointer 0, timeout counter 0, applied asynchronously.
REQ-032 Reset asserted mid-transfer aborts it: no ack is generated, and the requester re-issues the request after reset.
REQ-033 Reset deassertion is used synchronized to i_apb_clk by the integrating level; the first grant is possible in the first cycle after release.

Structure
REQ-034 Shared package apb_arb_pkg holds the state enum, APB_DW=32, APB_AW=32 and TIMEOUT_CYCLES default.
REQ-035 One sub-module, rr_arbiter, SHALL be used: a combinational round-robin grant from the request vector plus a registered pointer updated on grant.
REQ-036 Timeout counter width is $clog2(TIMEOUT_CYCLES).

Verification
REQ-037 Single write: req0 write addr 0x0000_0100 data 0xA5A5_5A5A, pready immediate -> psel in cycles 1-2, penable in cycle 2, ack[0] in cycle 3, err=0.
REQ-038 Read with 3 wait states: req1 read 0x0000_0200, pready at ACCESS+3 with prdata 0x1234_5678 -> ack[1] with rdata 0x1234_5678, err=0.
REQ-039 Contention: req0 and req1 valid continuously from reset -> grants alternate 0,1,0,1 with ack every 4 cycles.
REQ-040 Timeout: TIMEOUT_CYCLES=16, pready held 0 -> ack after 16 ACCESS cycles with err=1 and rdata=0; pserr=1 with pready -> err=1.
REQ-041 Reset mid-ACCESS: assert i_apb_rst_n=0 -> psel/penable/grant drop to 0 asynchronously, no ack; after release req0 is granted first.
